// File: rtl/frame_capture_pkg.sv
// Shared types and constants for the frame capture sink.
// FRAME_CAPTURE_CHECKSUM_EN (in the top) enables the per-frame pixel checksum.
package frame_capture_pkg;

  localparam int CSUM_W         = 32;
  localparam int PIX_DEPTH_DEF  = 8;
  localparam int ADDR_W_DEF     = 26;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef logic [3*PIX_DEPTH_DEF-1:0] pixel_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    pixel_t                data;
  } fifo_entry_t;

  // A request for zero frames behaves like a request for one.
  function automatic logic [7:0] frames_target(input logic [7:0] n);
    return (n == 8'd0) ? 8'd1 : n;
  endfunction

endpackage

// File: rtl/frame_capture_fifo.sv
// Synchronous first-word-fall-through FIFO: rdata_o shows the head entry
// whenever empty_o is low. A push on a full FIFO is accepted if a pop happens in the same cycle.
module frame_capture_fifo #(
  parameter int DATA_W = 50,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/frame_capture.sv
// Raster-stream sink: captures whole frames' active pixels into a linear store.
// Define FRAME_CAPTURE_CHECKSUM_EN to build the per-frame {r,g,b} checksum.
module frame_capture
  import frame_capture_pkg::*;
#(
  parameter int P_IMGDEPTH = 8,
  parameter int WIDTH      = 400,
  parameter int HEIGHT     = 300,
  parameter int H_DISP     = 320,
  parameter int V_DISP     = 240,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 26
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   num_frames,
  input  logic [$clog2(WIDTH+1)-1:0]   h_count_in,
  input  logic [$clog2(HEIGHT+1)-1:0]  v_count_in,
  input  logic [P_IMGDEPTH-1:0]        r_in,
  input  logic [P_IMGDEPTH-1:0]        g_in,
  input  logic [P_IMGDEPTH-1:0]        b_in,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [3*P_IMGDEPTH-1:0]      wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [7:0]                   frame_cnt,
  output logic [CSUM_W-1:0]            frame_sum,
  output logic                         frame_sum_valid,
  output state_e                       dbg_state_o
);

  localparam int HC_W  = $clog2(WIDTH+1);
  localparam int VC_W  = $clog2(HEIGHT+1);
  localparam int PIX_W = 3*P_IMGDEPTH;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } entry_t;

  logic [HC_W-1:0]   h1_q;
  logic [VC_W-1:0]   v1_q;
  logic [PIX_W-1:0]  pix1_q;
  logic              active1, sof1, eof1;

  state_e            state_q, state_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [7:0]        target_q, target_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              overflow_q, overflow_d;
  logic              clear_run, cap_en, frame_end;

  logic              capture_px, push, pop, drop;
  logic              fifo_full, fifo_empty;
  entry_t            push_entry, head_entry;

  // S1: one register stage on the incoming raster.
  always_ff @(posedge clk) begin
    if (rst) begin
      h1_q   <= '0;
      v1_q   <= '0;
      pix1_q <= '0;
    end else begin
      h1_q   <= h_count_in;
      v1_q   <= v_count_in;
      pix1_q <= {r_in, g_in, b_in};
    end
  end

  assign active1 = (h1_q < HC_W'(H_DISP)) && (v1_q < VC_W'(V_DISP));
  assign sof1    = (h1_q == '0) && (v1_q == '0);
  assign eof1    = (h1_q == HC_W'(WIDTH-1)) && (v1_q == VC_W'(HEIGHT-1));
  assign frame_end = (state_q == CAPTURE) && eof1;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    target_d    = target_q;
    clear_run   = 1'b0;
    cap_en      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = ARM;
          clear_run   = 1'b1;
          frame_cnt_d = '0;
          target_d    = frames_target(num_frames);
        end
      end
      // The frame-start pixel itself is captured on the ARM->CAPTURE cycle.
      ARM: begin
        if (sof1) begin
          state_d = CAPTURE;
          cap_en  = 1'b1;
        end
      end
      CAPTURE: begin
        cap_en = 1'b1;
        if (frame_end) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (frame_cnt_d == target_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port: wr_valid is high whenever the FIFO holds an entry; the head
  // entry (wr_addr/wr_data) stays put until the cycle wr_valid && wr_ready,
  // which is the only event that retires it. wr_ready may stay low forever.
  assign capture_px = cap_en && active1;
  assign pop        = wr_valid && wr_ready;
  assign push       = capture_px && (!fifo_full || pop);
  assign drop       = capture_px && fifo_full && !pop;

  // Dropped pixels still consume an address so later pixels land correctly.
  always_comb begin
    addr_d     = addr_q;
    overflow_d = overflow_q | drop;
    if (clear_run) begin
      addr_d     = '0;
      overflow_d = 1'b0;
    end else if (capture_px) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      target_q    <= '0;
      addr_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      target_q    <= target_d;
      addr_q      <= addr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign push_entry = '{addr: addr_q, data: pix1_q};

  frame_capture_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wr_valid    = !fifo_empty;
  assign wr_addr     = head_entry.addr;
  assign wr_data     = head_entry.data;
  assign busy        = (state_q == ARM) || (state_q == CAPTURE) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign overflow    = overflow_q;
  assign frame_cnt   = frame_cnt_q;
  assign dbg_state_o = state_q;

`ifdef FRAME_CAPTURE_CHECKSUM_EN
  logic [CSUM_W-1:0] sum_q, sum_d, sum_acc;
  logic [CSUM_W-1:0] frame_sum_q;
  logic              frame_sum_valid_q;

  // Dropped pixels are summed too: the checksum describes the source frame.
  assign sum_acc = sum_q + (capture_px ? CSUM_W'(pix1_q) : '0);

  always_comb begin
    sum_d = sum_acc;
    if (clear_run || frame_end) sum_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q             <= '0;
      frame_sum_q       <= '0;
      frame_sum_valid_q <= 1'b0;
    end else begin
      sum_q             <= sum_d;
      frame_sum_valid_q <= frame_end;
      if (frame_end) frame_sum_q <= sum_acc;
    end
  end

  assign frame_sum       = frame_sum_q;
  assign frame_sum_valid = frame_sum_valid_q;
`else
  assign frame_sum       = '0;
  assign frame_sum_valid = 1'b0;
`endif

endmodule

// File: doc/frame_capture.md
Name: frame_capture

Overview:
- Sink-side counterpart of the raster pixel source.
- Consumes the processed raster stream (h/v counters plus RGB) from the processing wrapper and extracts active-region pixels.
- Buffers them in a small FIFO and writes them as packed words to a linear frame store through a valid/ready write port.
- Captures a programmed number of whole frames, aligned to frame start, then drains and reports done.

Parameters:
- P_IMGDEPTH, 8, bits per colour component.
- WIDTH, 400, total pixels per line incl. blanking.
- HEIGHT, 300, total lines per frame incl. blanking.
- H_DISP, 320, active pixels per line.
- V_DISP, 240, active lines per frame.
- FIFO_DEPTH, 16, write-buffer entries (power of 2, >=4).
- ADDR_W, 26, write address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms capture (ignored unless IDLE or DONE).
- num_frames  in  8  frames to capture; sampled on start; 0 treated as 1.
- h_count_in  in  $clog2(WIDTH+1)  horizontal position of the current pixel.
- v_count_in  in  $clog2(HEIGHT+1)  vertical position of the current pixel.
- r_in/g_in/b_in  in  P_IMGDEPTH each  pixel components.
- wr_valid  out  1  write request.
- wr_ready  in  1  store accepts the write.
- wr_addr  out  ADDR_W  linear pixel address.
- wr_data  out  3*P_IMGDEPTH  {r,g,b}.
- busy  out  1  high in ARM/CAPTURE/DRAIN.
- done  out  1  high in DONE.
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full.
- frame_cnt  out  8  frames completed in the current run.
- frame_sum  out  32  per-frame checksum (see Optional Feature).
- frame_sum_valid  out  1  checksum strobe.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, FIFO empty, write address counter 0.
- Inputs h/v/rgb are registered once (stage S1). Active pixel: h<H_DISP && v<V_DISP, evaluated in S1.
- FSM states and transitions:
  - IDLE --start--> ARM. Clears frame_cnt, overflow and the address counter; latches num_frames.
  - ARM: waits for S1 at h=0,v=0, then enters CAPTURE in the same cycle. That pixel is captured.
  - CAPTURE: every active S1 pixel increments the address counter. If the FIFO is not full it also pushes {addr,data}. If the FIFO is full the pixel is dropped, overflow<=1, and the address still increments so later pixels land correctly.
  - Frame end (S1 at h=WIDTH-1,v=HEIGHT-1): frame_cnt++. If the new value equals the latched count, go to DRAIN.
  - DRAIN: no pushes; when the FIFO is empty and no write is outstanding, go to DONE.
  - DONE --start--> ARM, with the same clears as IDLE->ARM.
- Latency: an active pixel at the input in cycle t appears on wr_valid no earlier than t+2, when the FIFO is empty and wr_ready=1. Throughput is 1 word/cycle.
- Handshake: wr_valid, once high, holds wr_addr/wr_data stable until the cycle with wr_ready=1. A pop occurs only on wr_valid&&wr_ready. wr_ready may be low indefinitely.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push succeeds and there is no overflow.
- wr_addr wraps modulo 2^ADDR_W with no error.
- start while busy is ignored.
- rst asserted mid-capture: immediate return to the reset state. Pending FIFO data is discarded and wr_valid=0 on the next cycle.

Optional Feature:
- Macro: FRAME_CAPTURE_CHECKSUM_EN.
- With the macro: a 32-bit running sum of zero-extended {r,g,b} over every active pixel, including dropped ones. At frame end the sum is copied to frame_sum, frame_sum_valid pulses for 1 cycle, and the running sum clears.
- Without the macro: frame_sum=0, frame_sum_valid=0, and no adder is generated.

Decomposition:
- Package frame_capture_pkg:
  - state enum {IDLE,ARM,CAPTURE,DRAIN,DONE};
  - pixel_t typedef (3*P_IMGDEPTH packed);
  - FIFO entry struct {addr,data};
  - checksum width constant.
- One sub-module: frame_capture_fifo, a synchronous first-word-fall-through FIFO with full/empty flags, instantiated once.

Test Plan (WIDTH=8, HEIGHT=6, H_DISP=4, V_DISP=3, FIFO_DEPTH=4, P_IMGDEPTH=8):
1. start mid-frame (v=2), num_frames=1, wr_ready=1, pixel={h,v,h^v} -> no writes until the next frame start. Exactly 12 writes at addr 0..11 with matching data, then done=1, frame_cnt=1.
2. num_frames=2 -> 24 writes at addr 0..23, frame_cnt=2, overflow=0.
3. wr_ready=0 for a whole frame -> 4 writes queued, 8 dropped, overflow=1. Remaining writes keep correct addresses (e.g. the pixel at h=0,v=2 goes to addr 8).
4. wr_ready toggling 1/0 each cycle -> wr_addr/wr_data stable while wr_valid&&!wr_ready. No data loss; 12 writes total.
5. rst pulsed during CAPTURE -> next cycle wr_valid=0, busy=0, frame_cnt=0. A new start recaptures from addr 0.
6. FRAME_CAPTURE_CHECKSUM_EN defined, all pixels 0x010203 -> frame_sum=12*0x010203=0x0C1824 with a one-cycle frame_sum_valid per frame.
